// File: rtl/fft_pkg.sv
// Shared types for the MDC FFT datapath: complex lane format and commutator states.
package fft_pkg;

  localparam int unsigned CPLX_WIDTH = 16;
  localparam int unsigned CH_DEFAULT = 2;

  // One lane of a bus: re in the upper half, im in the lower half.
  typedef struct packed {
    logic signed [CPLX_WIDTH-1:0] re;
    logic signed [CPLX_WIDTH-1:0] im;
  } cplx_t;

  typedef cplx_t [CH_DEFAULT-1:0] ch_vec_t;

  typedef enum logic [1:0] {EMPTY, FILL, RUN, DRAIN} comm_state_e;

  function automatic int unsigned clamp_log2(input int unsigned sel, input int unsigned lim);
    return (sel > lim) ? lim : sel;
  endfunction

endpackage

// File: rtl/var_delay_line.sv
// Enabled shift register 2^LOG2_MAX_DELAY deep; output tap gives a delay of 2^tap_sel beats.
module var_delay_line #(
  parameter int unsigned LOG2_MAX_DELAY = 3,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned SEL_W = $clog2(LOG2_MAX_DELAY + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [SEL_W-1:0] tap_sel,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int unsigned DEPTH = 2 ** LOG2_MAX_DELAY;

  logic [DEPTH-1:0][WIDTH-1:0] taps;
  logic [WIDTH-1:0] tap_pts [LOG2_MAX_DELAY+1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      taps <= '0;
    end else if (en) begin
      taps <= {taps[DEPTH-2:0], din};
    end
  end

  // taps[k] holds the sample written k+1 beats ago.
  for (genvar g = 0; g <= LOG2_MAX_DELAY; g++) begin : g_tap
    assign tap_pts[g] = taps[(2 ** g) - 1];
  end

  assign dout = tap_pts[tap_sel];

endmodule

// File: rtl/mdc_delay_commutator.sv
// Radix-2 MDC delay commutator: pairs samples D apart across NUM_CH lockstep channels,
// with a runtime delay select, input handshake and self-generated drain.
module mdc_delay_commutator
  import fft_pkg::*;
#(
  parameter int unsigned LOG2_MAX_DELAY = 3,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_CH = 2,
  localparam int unsigned SEL_W = $clog2(LOG2_MAX_DELAY + 1),
  localparam int unsigned VEC_W = NUM_CH * 2 * DATA_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SEL_W-1:0] delay_log2,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VEC_W-1:0] x0,
  input  logic [VEC_W-1:0] x1,
  input  logic             flush,
  output logic [VEC_W-1:0] y0,
  output logic [VEC_W-1:0] y1,
  output logic             commutator_out_valid,
  output logic             busy
);

  localparam int unsigned CNT_W = LOG2_MAX_DELAY + 1;

  comm_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, drain_q, drain_d, d_last;
  logic [SEL_W-1:0] sel_q, sel_d, sel_in, sel_eff;
  logic             primed_q, primed_d;
  logic             accept, drain_beat, beat, sw;
  logic [VEC_W-1:0] xa, xb, pre_out, c_in, d_in, post_out;

  assign in_ready   = (state_q != DRAIN);
  assign busy       = (state_q != EMPTY);
  assign accept     = in_valid && in_ready;
  assign drain_beat = (state_q == DRAIN);
  assign beat       = accept || drain_beat;

  assign sel_in  = SEL_W'(clamp_log2(32'(delay_log2), LOG2_MAX_DELAY));
  // The first beat of a frame already runs with the newly selected delay.
  assign sel_eff = (state_q == EMPTY) ? sel_in : sel_q;
  assign d_last  = (CNT_W'(1) << sel_eff) - CNT_W'(1);
  assign sw      = cnt_q[sel_eff];

  assign xa = drain_beat ? '0 : x0;
  assign xb = drain_beat ? '0 : x1;

  var_delay_line #(
    .LOG2_MAX_DELAY (LOG2_MAX_DELAY),
    .WIDTH          (VEC_W)
  ) u_pre_delay (
    .clk     (clk),
    .reset   (reset),
    .en      (beat),
    .tap_sel (sel_eff),
    .din     (xb),
    .dout    (pre_out)
  );

  assign c_in = sw ? pre_out : xa;
  assign d_in = sw ? xa : pre_out;

  var_delay_line #(
    .LOG2_MAX_DELAY (LOG2_MAX_DELAY),
    .WIDTH          (VEC_W)
  ) u_post_delay (
    .clk     (clk),
    .reset   (reset),
    .en      (beat),
    .tap_sel (sel_eff),
    .din     (c_in),
    .dout    (post_out)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    drain_d  = drain_q;
    sel_d    = sel_q;
    primed_d = primed_q;
    // primed marks that beat D-1 has passed, so every later beat yields a pair.
    if (beat) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == d_last) primed_d = 1'b1;
    end
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          sel_d   = sel_in;
          state_d = (sel_in == '0) ? RUN : FILL;
        end
      end
      FILL: begin
        if (flush) state_d = DRAIN;
        else if (accept && (cnt_q == d_last)) state_d = RUN;
      end
      RUN: begin
        if (flush) state_d = DRAIN;
      end
      DRAIN: begin
        drain_d = drain_q + CNT_W'(1);
        if (drain_q == d_last) begin
          state_d  = EMPTY;
          cnt_d    = '0;
          drain_d  = '0;
          primed_d = 1'b0;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q              <= EMPTY;
      cnt_q                <= '0;
      drain_q              <= '0;
      sel_q                <= '0;
      primed_q             <= 1'b0;
      y0                   <= '0;
      y1                   <= '0;
      commutator_out_valid <= 1'b0;
    end else begin
      state_q              <= state_d;
      cnt_q                <= cnt_d;
      drain_q              <= drain_d;
      sel_q                <= sel_d;
      primed_q             <= primed_d;
      commutator_out_valid <= beat && primed_q;
      if (beat) begin
        y0 <= post_out;
        y1 <= d_in;
      end
    end
  end

endmodule
